// File: rtl/card_dealer_pkg.sv
// Shared constants, FSM state encoding and card scoring for the card dealer.
package card_dealer_pkg;

  localparam int DEFAULT_DECK_SIZE   = 52;
  localparam int DEFAULT_LOAD_STRIDE = 2;
  localparam int RANKS_PER_SUIT      = 13;
  localparam int CARD_W              = 6;
  localparam int NUM_CARDS           = 52;
  localparam logic [CARD_W-1:0] MAX_CARD = CARD_W'(NUM_CARDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_EMPTY = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  // Blackjack-style value: Ace counts 11, face cards count 10.
  function automatic logic [3:0] rank_points(input logic [3:0] rank);
    if (rank == 4'd0) begin
      return 4'd11;
    end else if (rank >= 4'd10) begin
      return 4'd10;
    end else begin
      return rank + 4'd1;
    end
  endfunction

endpackage

// File: rtl/card_dealer_card_decode.sv
// Combinational split of a card index into rank, suit and points.
module card_decode
  import card_dealer_pkg::*;
(
  input  logic [CARD_W-1:0] card_i,
  output logic [3:0]        rank_o,
  output logic [1:0]        suit_o,
  output logic [3:0]        points_o
);

  // Index -> rank/suit by division by the suit length; points follow the rank.
  always_comb begin
    rank_o   = 4'(card_i % CARD_W'(RANKS_PER_SUIT));
    suit_o   = 2'(card_i / CARD_W'(RANKS_PER_SUIT));
    points_o = rank_points(rank_o);
  end

endmodule

// File: rtl/card_dealer.sv
// Card dealer: captures a shuffled deck from the shuffler, validates it,
// then pops cards in arrival order on request.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for load_flag to start a load
// ST_LOAD  | capturing card_in every LOAD_STRIDE cycles, checking dups
// ST_READY | deck complete, deal_req pops one card per cycle
// ST_EMPTY | all cards dealt, requests ignored
// ST_ERROR | bad or duplicate card, or load aborted; restart to leave
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter int DECK_SIZE   = DEFAULT_DECK_SIZE,
  parameter int LOAD_STRIDE = DEFAULT_LOAD_STRIDE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_flag,
  input  logic [CARD_W-1:0] card_in,
  input  logic              restart,
  input  logic              deal_req,
  output logic              deal_valid,
  output logic [CARD_W-1:0] deal_card,
  output logic [3:0]        deal_rank,
  output logic [1:0]        deal_suit,
  output logic [3:0]        deal_points,
  output logic [5:0]        cards_left,
  output logic              ready,
  output logic              deck_empty,
  output logic              load_error
);

  localparam int IDX_W = $clog2(DECK_SIZE + 1);
  localparam int STR_W = (LOAD_STRIDE > 1) ? $clog2(LOAD_STRIDE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(DECK_SIZE - 1);
  localparam logic [5:0]       FULL_COUNT    = 6'(DECK_SIZE);
  localparam logic [STR_W-1:0] STRIDE_RELOAD = STR_W'(LOAD_STRIDE - 1);

  state_t                state_q, state_d;
  logic [STR_W-1:0]      stride_q, stride_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [5:0]            cards_left_q, cards_left_d;
  logic [NUM_CARDS-1:0]  seen_q, seen_d;
  logic                  deal_valid_q, deal_valid_d;
  logic [CARD_W-1:0]     deal_card_q, deal_card_d;
  logic [3:0]            deal_rank_q, deal_rank_d;
  logic [1:0]            deal_suit_q, deal_suit_d;
  logic [3:0]            deal_points_q, deal_points_d;
  logic                  deck_we;

  logic [CARD_W-1:0]     deck_q [DECK_SIZE];
  logic [CARD_W-1:0]     rd_card;
  logic [3:0]            rd_rank;
  logic [1:0]            rd_suit;
  logic [3:0]            rd_points;
  logic                  card_ok;

  assign rd_card = deck_q[rd_idx_q];
  assign card_ok = (card_in <= MAX_CARD) && !seen_q[card_in];

  card_decode u_decode (
    .card_i   (rd_card),
    .rank_o   (rd_rank),
    .suit_o   (rd_suit),
    .points_o (rd_points)
  );

  // Next-state and datapath updates; restart overrides everything else.
  always_comb begin
    state_d       = state_q;
    stride_d      = stride_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    cards_left_d  = cards_left_q;
    seen_d        = seen_q;
    deal_valid_d  = 1'b0;
    deal_card_d   = deal_card_q;
    deal_rank_d   = deal_rank_q;
    deal_suit_d   = deal_suit_q;
    deal_points_d = deal_points_q;
    deck_we       = 1'b0;

    if (restart) begin
      state_d      = ST_IDLE;
      stride_d     = '0;
      wr_idx_d     = '0;
      rd_idx_d     = '0;
      cards_left_d = '0;
      seen_d       = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_flag) begin
            state_d  = ST_LOAD;
            stride_d = '0;
            wr_idx_d = '0;
            rd_idx_d = '0;
            seen_d   = '0;
          end
        end
        ST_LOAD: begin
          if (!load_flag) begin
            state_d = ST_ERROR;
          end else if (stride_q == '0) begin
            if (!card_ok) begin
              state_d = ST_ERROR;
            end else begin
              deck_we          = 1'b1;
              seen_d[card_in]  = 1'b1;
              wr_idx_d         = wr_idx_q + IDX_W'(1);
              stride_d         = STRIDE_RELOAD;
              if (wr_idx_q == LAST_IDX) begin
                state_d      = ST_READY;
                cards_left_d = FULL_COUNT;
              end
            end
          end else begin
            stride_d = stride_q - STR_W'(1);
          end
        end
        ST_READY: begin
          if (deal_req) begin
            deal_valid_d  = 1'b1;
            deal_card_d   = rd_card;
            deal_rank_d   = rd_rank;
            deal_suit_d   = rd_suit;
            deal_points_d = rd_points;
            rd_idx_d      = rd_idx_q + IDX_W'(1);
            cards_left_d  = cards_left_q - 6'd1;
            if (cards_left_q == 6'd1) begin
              state_d = ST_EMPTY;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      stride_q      <= '0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      cards_left_q  <= '0;
      seen_q        <= '0;
      deal_valid_q  <= 1'b0;
      deal_card_q   <= '0;
      deal_rank_q   <= '0;
      deal_suit_q   <= '0;
      deal_points_q <= '0;
    end else begin
      state_q       <= state_d;
      stride_q      <= stride_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      cards_left_q  <= cards_left_d;
      seen_q        <= seen_d;
      deal_valid_q  <= deal_valid_d;
      deal_card_q   <= deal_card_d;
      deal_rank_q   <= deal_rank_d;
      deal_suit_q   <= deal_suit_d;
      deal_points_q <= deal_points_d;
    end
  end

  // Deck storage is never read before being rewritten, so it carries no reset.
  always_ff @(posedge clk) begin
    if (deck_we) begin
      deck_q[wr_idx_q] <= card_in;
    end
  end

  assign deal_valid  = deal_valid_q;
  assign deal_card   = deal_card_q;
  assign deal_rank   = deal_rank_q;
  assign deal_suit   = deal_suit_q;
  assign deal_points = deal_points_q;
  assign cards_left  = cards_left_q;
  assign ready       = (state_q == ST_READY);
  assign deck_empty  = (state_q == ST_EMPTY);
  assign load_error  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: queue-based deck model checked every cycle,
// plus directed checks on the key scenarios.
module tb_card_dealer;

  localparam int DECK   = 52;
  localparam int STRIDE = 2;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;
  localparam int M_EMPTY = 3;
  localparam int M_ERROR = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_flag;
  logic [5:0] card_in;
  logic       restart;
  logic       deal_req;
  logic       deal_valid;
  logic [5:0] deal_card;
  logic [3:0] deal_rank;
  logic [1:0] deal_suit;
  logic [3:0] deal_points;
  logic [5:0] cards_left;
  logic       ready;
  logic       deck_empty;
  logic       load_error;

  card_dealer #(.DECK_SIZE(DECK), .LOAD_STRIDE(STRIDE)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_flag   (load_flag),
    .card_in     (card_in),
    .restart     (restart),
    .deal_req    (deal_req),
    .deal_valid  (deal_valid),
    .deal_card   (deal_card),
    .deal_rank   (deal_rank),
    .deal_suit   (deal_suit),
    .deal_points (deal_points),
    .cards_left  (cards_left),
    .ready       (ready),
    .deck_empty  (deck_empty),
    .load_error  (load_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int m_mode;
  int cyc;
  int r0;
  int m_deck[$];
  bit m_seen[64];
  int m_valid, m_card, m_rank, m_suit, m_pts, m_left;
  int perm[DECK];
  int pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_valid = 0;
    if (!rst) begin
      m_mode = M_IDLE;
      m_deck.delete();
      m_seen = '{default: 0};
      m_card = 0; m_rank = 0; m_suit = 0; m_pts = 0; m_left = 0;
    end else if (restart) begin
      m_mode = M_IDLE;
      m_deck.delete();
      m_seen = '{default: 0};
      m_left = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (load_flag) begin
          m_mode = M_LOAD;
          r0 = cyc;
          m_deck.delete();
          m_seen = '{default: 0};
        end
        M_LOAD: begin
          if (!load_flag) begin
            m_mode = M_ERROR;
          end else if ((cyc - r0 - 1) % STRIDE == 0) begin
            if (card_in > 51 || m_seen[card_in]) begin
              m_mode = M_ERROR;
            end else begin
              m_seen[card_in] = 1;
              m_deck.push_back(int'(card_in));
              if (m_deck.size() == DECK) begin
                m_mode = M_READY;
                m_left = DECK;
              end
            end
          end
        end
        M_READY: if (deal_req) begin
          m_valid = 1;
          m_card  = m_deck.pop_front();
          m_rank  = m_card % 13;
          m_suit  = m_card / 13;
          m_pts   = (m_rank == 0) ? 11 : (m_rank >= 10) ? 10 : m_rank + 1;
          m_left--;
          if (m_left == 0) m_mode = M_EMPTY;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("deal_valid",  32'(deal_valid),  32'(m_valid));
    chk("deal_card",   32'(deal_card),   32'(m_card));
    chk("deal_rank",   32'(deal_rank),   32'(m_rank));
    chk("deal_suit",   32'(deal_suit),   32'(m_suit));
    chk("deal_points", 32'(deal_points), 32'(m_pts));
    chk("cards_left",  32'(cards_left),  32'(m_left));
    chk("ready",       32'(ready),       32'(m_mode == M_READY));
    chk("deck_empty",  32'(deck_empty),  32'(m_mode == M_EMPTY));
    chk("load_error",  32'(load_error),  32'(m_mode == M_ERROR));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic shuffle();
    for (int i = 0; i < DECK; i++) perm[i] = i;
    for (int i = DECK - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
  endtask

  // Starts from IDLE with load_flag low; presents n cards from perm on capture edges.
  task automatic load_perm(input int n, input bit rand_req);
    load_flag = 1'b1;
    deal_req  = rand_req ? 1'($urandom_range(1, 0)) : 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      card_in  = 6'(perm[i]);
      deal_req = rand_req ? 1'($urandom_range(1, 0)) : 1'b0;
      tick();
      card_in  = 6'($urandom_range(63, 0));
      deal_req = (rand_req && i != n - 1) ? 1'($urandom_range(1, 0)) : 1'b0;
      tick();
    end
    deal_req = 1'b0;
  endtask

  task automatic do_restart();
    load_flag = 1'b0;
    deal_req  = 1'b0;
    restart   = 1'b1;
    tick();
    restart   = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; load_flag = 1'b0; card_in = '0; restart = 1'b0; deal_req = 1'b0;
    cyc = 0; r0 = 0; m_mode = M_IDLE;
    m_valid = 0; m_card = 0; m_rank = 0; m_suit = 0; m_pts = 0; m_left = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Descending deck, full drain.
    for (int i = 0; i < DECK; i++) perm[i] = 51 - i;
    load_perm(DECK, 1'b0);
    chk("A_ready", 32'(ready), 32'd1);
    chk("A_left", 32'(cards_left), 32'd52);
    deal_req = 1'b1;
    tick();
    chk("A_first_valid", 32'(deal_valid), 32'd1);
    chk("A_first_card", 32'(deal_card), 32'd51);
    chk("A_first_rank", 32'(deal_rank), 32'd12);
    chk("A_first_suit", 32'(deal_suit), 32'd3);
    chk("A_first_pts", 32'(deal_points), 32'd10);
    pulses = 1;
    for (int i = 0; i < 51; i++) begin
      tick();
      if (deal_valid === 1'b1) pulses++;
    end
    chk("A_pulses", 32'(pulses), 32'd52);
    chk("A_last_card", 32'(deal_card), 32'd0);
    chk("A_last_rank", 32'(deal_rank), 32'd0);
    chk("A_last_pts", 32'(deal_points), 32'd11);
    chk("A_empty", 32'(deck_empty), 32'd1);
    chk("A_left0", 32'(cards_left), 32'd0);
    repeat (3) tick();
    chk("A_no_more_deal", 32'(deal_valid), 32'd0);
    chk("A_card_held", 32'(deal_card), 32'd0);
    do_restart();

    // Duplicate on third capture.
    perm[0] = 7; perm[1] = 9; perm[2] = 7;
    load_perm(3, 1'b1);
    chk("B_dup_error", 32'(load_error), 32'd1);
    chk("B_not_ready", 32'(ready), 32'd0);
    deal_req = 1'b1;
    repeat (4) tick();
    chk("B_stuck_error", 32'(load_error), 32'd1);
    do_restart();

    // Out-of-range card, then restart.
    perm[0] = 5; perm[1] = 60;
    load_perm(2, 1'b1);
    chk("C_range_error", 32'(load_error), 32'd1);
    do_restart();
    chk("C_ready0", 32'(ready), 32'd0);
    chk("C_empty0", 32'(deck_empty), 32'd0);
    chk("C_error0", 32'(load_error), 32'd0);

    // Reset after 10 deals, then fresh random deck with random requests.
    shuffle();
    load_perm(DECK, 1'b1);
    deal_req = 1'b1;
    repeat (10) tick();
    chk("D_left42", 32'(cards_left), 32'd42);
    rst = 1'b0;
    load_flag = 1'b0;
    tick();
    rst = 1'b1;
    deal_req = 1'b0;
    chk("D_rst_valid", 32'(deal_valid), 32'd0);
    chk("D_rst_card", 32'(deal_card), 32'd0);
    chk("D_rst_rank", 32'(deal_rank), 32'd0);
    chk("D_rst_suit", 32'(deal_suit), 32'd0);
    chk("D_rst_pts", 32'(deal_points), 32'd0);
    chk("D_rst_left", 32'(cards_left), 32'd0);
    chk("D_rst_ready", 32'(ready), 32'd0);
    chk("D_rst_empty", 32'(deck_empty), 32'd0);
    chk("D_rst_error", 32'(load_error), 32'd0);
    tick();
    shuffle();
    load_perm(DECK, 1'b1);
    chk("D_reload_left", 32'(cards_left), 32'd52);
    repeat (80) begin
      deal_req = 1'($urandom_range(1, 0));
      tick();
    end
    deal_req = 1'b1;
    repeat (60) tick();
    chk("D_drained", 32'(deck_empty), 32'd1);
    do_restart();

    // Reset in the middle of a load.
    shuffle();
    load_perm(5, 1'b1);
    rst = 1'b0;
    load_flag = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("E_idle_after_rst", 32'(ready | deck_empty | load_error), 32'd0);

    // Restart beats deal_req in READY.
    shuffle();
    load_perm(DECK, 1'b0);
    deal_req = 1'b1;
    tick();
    restart = 1'b1;
    load_flag = 1'b0;
    tick();
    restart = 1'b0;
    deal_req = 1'b0;
    chk("F_no_valid", 32'(deal_valid), 32'd0);
    chk("F_not_ready", 32'(ready), 32'd0);
    chk("F_left0", 32'(cards_left), 32'd0);
    tick();

    // load_flag dropped mid-load.
    shuffle();
    load_perm(10, 1'b1);
    load_flag = 1'b0;
    tick();
    chk("G_abort_error", 32'(load_error), 32'd1);
    do_restart();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter DECK_SIZE, default 52, number of cards captured per load.
REQ-002 SHALL have parameter LOAD_STRIDE, default 2, clock cycles between successive card_in values.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port load_flag  input  1  shuffler load-in-progress; stays high after the last card.
REQ-006 SHALL have port card_in  input  6  card index 0..51, updated every LOAD_STRIDE cycles.
REQ-007 SHALL have port restart  input  1  one-cycle pulse; clears deck, returns to IDLE.
REQ-008 SHALL have port deal_req  input  1  pop request; one card per cycle sampled high.
REQ-009 SHALL have port deal_valid  output  1  one-cycle pulse; deal_* outputs valid.
REQ-010 SHALL have port deal_card  output  6  dealt card index.
REQ-011 SHALL have port deal_rank  output  4  card_index mod 13 (0=Ace .. 12=King).
REQ-012 SHALL have port deal_suit  output  2  card_index / 13.
REQ-013 SHALL have port deal_points  output  4  Ace=11, ranks 1..9 = rank+1, ranks 10..12 = 10.
REQ-014 SHALL have port cards_left  output  6  undealt cards in deck.
REQ-015 SHALL have port ready, deck_empty, load_error  output  1 each  state flags.

Function
REQ-016 SHALL implement states IDLE, LOAD, READY, EMPTY, ERROR.
REQ-017 IDLE: first cycle load_flag sampled 1 (edge R0) -> LOAD; stride counter cleared.
REQ-018 LOAD: card_in captured at edges R0+1, R0+1+LOAD_STRIDE, ...; DECK_SIZE captures total, stored at write index 0..DECK_SIZE-1.
REQ-019 Each capture SHALL check card_in <= 51 and not already seen (DECK_SIZE-bit seen mask); violation -> ERROR at that edge.
REQ-020 load_flag sampled 0 while in LOAD -> ERROR.
REQ-021 After capture DECK_SIZE -> READY, cards_left=DECK_SIZE; load_flag remaining high is ignored thereafter.
REQ-022 READY: deal_req=1 at edge N -> deal_valid=1 during cycle after N with card at read index (arrival order, first captured dealt first); read index +1, cards_left -1.
REQ-023 deal_req held high SHALL deal one card per cycle, back-to-back.
REQ-024 Deal leaving cards_left=0 -> EMPTY on same edge; deal_req in EMPTY, IDLE, LOAD, ERROR ignored, deal_valid stays 0.
REQ-025 deal_rank/suit/points SHALL be registered alongside deal_card and hold value between deals.
REQ-026 restart=1 SHALL take priority over deal_req and load activity: next state IDLE, mask/pointers/cards_left cleared.
REQ-027 ERROR exits only via restart or reset.
REQ-028 ready=1 only in READY; deck_empty=1 only in EMPTY; load_error=1 only in ERROR.

Reset
REQ-029 rst=0 at a clock edge SHALL force IDLE, deal_valid=0, deal_card=0, deal_rank=0, deal_suit=0, deal_points=0, cards_left=0, ready=0, deck_empty=0, load_error=0, seen mask cleared, mid-load or mid-deal included.
REQ-030 Deck storage contents need not be reset.

Structure
REQ-031 Shared package SHALL hold DECK_SIZE, ranks-per-suit (13), card width (6), state encoding, and the rank-to-points function.
REQ-032 Card decode (index -> rank, suit, points) SHALL be a sub-module card_decode, combinational, instantiated once on the read path.

Verification
REQ-033 load_flag rises, card_in = 51,50,...,0 every 2 cycles -> ready after 52 captures, cards_left=52; first deal gives card 51, rank 12, suit 3, points 10.
REQ-034 READY, deal_req held 52 cycles -> 52 consecutive deal_valid pulses, last card 0 (rank 0, points 11), deck_empty=1, cards_left=0; further deal_req gives no deal_valid.
REQ-035 Third captured card_in duplicates first (e.g. 7,9,7) -> load_error=1 at that capture, ready never asserts.
REQ-036 card_in=60 during LOAD -> load_error=1; restart pulse -> IDLE, all flags 0.
REQ-037 rst=0 after 10 deals -> all outputs 0 next cycle; new load yields fresh 52-card deck.
REQ-038 restart and deal_req high same cycle in READY -> no deal_valid, state IDLE, cards_left=0.
